// File: rtl/inst_mem_loader_pkg.sv
// Shared constants, loader state encoding and write-port payload for the instruction memory loader.
package inst_mem_loader_pkg;

    localparam int unsigned BUS_W            = 32;
    localparam int unsigned LOADER_HDR_BYTES = 2;
    localparam int unsigned WORD_BYTES       = 4;
    localparam int unsigned WORD_W           = 8 * WORD_BYTES;
    localparam int unsigned CNT_W            = $clog2(WORD_BYTES);
    localparam int unsigned IDX_W            = 8 * LOADER_HDR_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_CHECK  = 3'd6
    } loader_state_e;

    typedef struct packed {
        logic [BUS_W-1:0]  addr;
        logic [WORD_W-1:0] data;
    } im_wr_t;

endpackage

// File: rtl/inst_mem_loader_byte_word_packer.sv
// Packs a little-endian byte stream into instruction words; the completed word and its
// wordReady pulse are presented combinationally in the cycle of the last byte.
module byte_word_packer
    import inst_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready_c
);

    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              last_byte;

    // Bytes enter at the top and move down, so byte 0 ends up in the LSBs.
    always_comb begin
        last_byte    = (byte_cnt_q == CNT_W'(WORD_BYTES - 1));
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_c       = {byte_in, shift_q[WORD_W-1:8]};
        word_ready_c = 1'b0;
        if (clr) begin
            byte_cnt_d = '0;
            shift_d    = '0;
        end else if (byte_valid) begin
            shift_d      = {byte_in, shift_q[WORD_W-1:8]};
            byte_cnt_d   = last_byte ? '0 : byte_cnt_q + CNT_W'(1);
            word_ready_c = last_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a runtime instruction image from a byte stream into instruction memory, holding the CPU meanwhile.
// Optional trailing XOR checksum byte enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 8192,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rxValid,
    input  logic [7:0]        rxData,
    output logic              rxReady,
    output logic              imWrEn,
    output logic [BUS_W-1:0]  imWrAddr,
    output logic [WORD_W-1:0] imWrData,
    output logic              cpuHold,
    output logic              loadDone,
    output logic              loadErr
);

    loader_state_e     state_q, state_d;
    logic [7:0]        n_lo_q, n_lo_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    im_wr_t            wr_q, wr_d;
    logic              rx_ready_q, rx_ready_d;
    logic              im_wr_en_q, im_wr_en_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              hs;
    logic [IDX_W-1:0]  n_hdr;
    logic              pk_clr;
    logic              pk_valid;
    logic [WORD_W-1:0] pk_word;
    logic              pk_word_ready;

    byte_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (pk_clr),
        .byte_valid   (pk_valid),
        .byte_in      (rxData),
        .word_c       (pk_word),
        .word_ready_c (pk_word_ready)
    );

    // Next state plus registered-output values derived from the state being entered.
    always_comb begin
        hs          = rxValid && rx_ready_q;
        n_hdr       = {rxData, n_lo_q};
        state_d     = state_q;
        n_lo_d      = n_lo_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        wr_d        = wr_q;
        load_err_d  = load_err_q;
        pk_clr      = 1'b0;
        pk_valid    = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LEN_LO;
                    load_err_d = 1'b0;
                    word_idx_d = '0;
                    pk_clr     = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (hs) begin
                    n_lo_d  = rxData;
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (hs) begin
                    n_d        = n_hdr;
                    word_idx_d = '0;
                    if (32'(n_hdr) > MAX_WORDS) begin
                        load_err_d = 1'b1;
                        state_d    = ST_DONE;
                    end else if (n_hdr == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                pk_valid = hs;
`ifdef INST_LOADER_CHECKSUM_EN
                if (hs) csum_d = csum_q ^ rxData;
`endif
                if (pk_word_ready) begin
                    wr_d.addr = BUS_W'(word_idx_q) + BUS_W'(BASE_ADDR);
                    wr_d.data = pk_word;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + IDX_W'(1);
                if (word_idx_d == n_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (hs) begin
                    if (rxData != csum_q) load_err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        rx_ready_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                      (state_d == ST_DATA)   || (state_d == ST_CHECK);
        im_wr_en_d  = (state_d == ST_WRITE);
        load_done_d = (state_d == ST_DONE);
`ifdef INST_LOADER_CHECKSUM_EN
        // A failed image keeps the CPU parked even though the load has finished.
        cpu_hold_d  = !((state_d == ST_DONE) && !load_err_d);
`else
        cpu_hold_d  = (state_d != ST_DONE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_lo_q      <= '0;
            n_q         <= '0;
            word_idx_q  <= '0;
            wr_q        <= '0;
            rx_ready_q  <= 1'b0;
            im_wr_en_q  <= 1'b0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_lo_q      <= n_lo_d;
            n_q         <= n_d;
            word_idx_q  <= word_idx_d;
            wr_q        <= wr_d;
            rx_ready_q  <= rx_ready_d;
            im_wr_en_q  <= im_wr_en_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`endif

    assign rxReady  = rx_ready_q;
    assign imWrEn   = im_wr_en_q;
    assign imWrAddr = wr_q.addr;
    assign imWrData = wr_q.data;
    assign cpuHold  = cpu_hold_q;
    assign loadDone = load_done_q;
    assign loadErr  = load_err_q;

endmodule
